cin_multi_parallel_sync: RTL and testbench

Multi-channel, parameterised successor to the single-lane CIN parallel synchroniser. It sits in the SYSCLK domain behind the RXCLK→SYSCLK transfer stage and accepts NCH independent NBITS-wide deserialised lanes. For each lane it finds word alignment against the training pattern automatically, qualifies lock over several consecutive words, and then emits WORD_BITS-wide commands with a one-cycle valid strobe. Per-lane bit-error flags, snapshot capture and optional saturating error counters support link training from the register core.

---
 rtl/cin_multi_parallel_sync.sv | 194 +++++++++++++++++++
 tb/tb_cin_multi_parallel_sync.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cin_multi_parallel_sync.sv
// rtl/cin_multi_parallel_sync.sv - multi-lane CIN word aligner, lock qualifier and command extractor
// Optional per-lane saturating error counters under `CIN_SYNC_ERRCNT_EN.
module cin_multi_parallel_sync #(
  parameter int NCH        = 1,
  parameter int NBITS      = 4,
  parameter int WORD_BITS  = 32,
  parameter logic [WORD_BITS-1:0] TRAIN_SEQUENCE = WORD_BITS'(32'hA55A6996),
  parameter int LOCK_COUNT = 4,
  parameter int ERR_BITS   = 16
) (
  input  logic                     sysclk_i,
  input  logic                     rst_i,
  input  logic [NCH*NBITS-1:0]     cin_i,
  input  logic                     lock_i,
  input  logic                     capture_i,
  input  logic                     err_clr_i,
  output logic [NCH-1:0]           locked_o,
  output logic [NCH*WORD_BITS-1:0] cin_parallel_o,
  output logic [NCH-1:0]           cin_parallel_valid_o,
  output logic [NCH-1:0]           cin_biterr_o,
  output logic [NCH*WORD_BITS-1:0] capture_data_o,
  output logic [NCH*ERR_BITS-1:0]  err_count_o
);

  localparam int NPHASE = WORD_BITS / NBITS;
  localparam int PW     = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam int MW     = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

  state_t               state_q [NCH];
  state_t               state_d [NCH];
  logic [WORD_BITS-1:0] sr_q    [NCH];
  logic [WORD_BITS-1:0] sr_d    [NCH];
  logic [WORD_BITS-1:0] par_q   [NCH];
  logic [WORD_BITS-1:0] par_d   [NCH];
  logic [WORD_BITS-1:0] cap_q   [NCH];
  logic [WORD_BITS-1:0] cap_d   [NCH];
  logic [PW-1:0]        off_q   [NCH];
  logic [PW-1:0]        off_d   [NCH];
  logic [MW-1:0]        mcnt_q  [NCH];
  logic [MW-1:0]        mcnt_d  [NCH];
  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH-1:0]       biterr_q, biterr_d;
  logic [NCH-1:0]       boundary, match;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic                 lock_q, lock_d;
  logic                 armed_q, armed_d;
  logic                 lock_rise;

  // armed_q masks the first cycle after reset so a lock_i held high gives no edge
  assign lock_rise = lock_i & ~lock_q & armed_q;
  assign lock_d    = lock_i;
  assign armed_d   = 1'b1;
  assign pcnt_d    = (pcnt_q == PW'(NPHASE - 1)) ? '0 : pcnt_q + 1'b1;

  always_comb begin
    boundary = '0;
    match    = '0;
    for (int c = 0; c < NCH; c++) begin
      sr_d[c]     = {sr_q[c][WORD_BITS-NBITS-1:0], cin_i[c*NBITS +: NBITS]};
      boundary[c] = (pcnt_q == off_q[c]);
      match[c]    = (sr_q[c] == TRAIN_SEQUENCE);
    end
  end

  always_comb begin
    valid_d  = '0;
    biterr_d = '0;
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      off_d[c]   = off_q[c];
      mcnt_d[c]  = mcnt_q[c];
      par_d[c]   = par_q[c];
      cap_d[c]   = capture_i ? sr_q[c] : cap_q[c];
      if (lock_rise) begin
        state_d[c] = ST_HUNT;
        mcnt_d[c]  = '0;
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            if (boundary[c] && !match[c]) biterr_d[c] = 1'b1;
          end
          ST_HUNT: begin
            if (match[c]) begin
              off_d[c]   = pcnt_q;
              mcnt_d[c]  = MW'(1);
              state_d[c] = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (boundary[c]) begin
              if (match[c]) begin
                mcnt_d[c] = mcnt_q[c] + 1'b1;
                if (mcnt_q[c] == MW'(LOCK_COUNT - 1)) state_d[c] = ST_LOCKED;
              end else begin
                mcnt_d[c]  = '0;
                state_d[c] = ST_HUNT;
              end
            end
          end
          ST_LOCKED: begin
            if (boundary[c]) begin
              par_d[c]    = sr_q[c];
              valid_d[c]  = 1'b1;
              biterr_d[c] = !match[c];
            end
          end
          default: state_d[c] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q   <= '0;
      lock_q   <= 1'b0;
      armed_q  <= 1'b0;
      valid_q  <= '0;
      biterr_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= ST_IDLE;
        sr_q[c]    <= '0;
        par_q[c]   <= '0;
        cap_q[c]   <= '0;
        off_q[c]   <= '0;
        mcnt_q[c]  <= '0;
      end
    end else begin
      pcnt_q   <= pcnt_d;
      lock_q   <= lock_d;
      armed_q  <= armed_d;
      valid_q  <= valid_d;
      biterr_q <= biterr_d;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        sr_q[c]    <= sr_d[c];
        par_q[c]   <= par_d[c];
        cap_q[c]   <= cap_d[c];
        off_q[c]   <= off_d[c];
        mcnt_q[c]  <= mcnt_d[c];
      end
    end
  end

  always_comb begin
    cin_parallel_o = '0;
    capture_data_o = '0;
    locked_o       = '0;
    for (int c = 0; c < NCH; c++) begin
      cin_parallel_o[c*WORD_BITS +: WORD_BITS] = par_q[c];
      capture_data_o[c*WORD_BITS +: WORD_BITS] = cap_q[c];
      locked_o[c] = (state_q[c] == ST_LOCKED);
    end
  end

  assign cin_parallel_valid_o = valid_q;
  assign cin_biterr_o         = biterr_q;

`ifdef CIN_SYNC_ERRCNT_EN
  logic [ERR_BITS-1:0] errcnt_q [NCH];
  logic [ERR_BITS-1:0] errcnt_d [NCH];

  // clear beats a coincident increment; counts saturate at all-ones
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      errcnt_d[c] = errcnt_q[c];
      if (err_clr_i)
        errcnt_d[c] = '0;
      else if (biterr_d[c] && (errcnt_q[c] != {ERR_BITS{1'b1}}))
        errcnt_d[c] = errcnt_q[c] + 1'b1;
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NCH; c++) errcnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) errcnt_q[c] <= errcnt_d[c];
    end
  end

  always_comb begin
    err_count_o = '0;
    for (int c = 0; c < NCH; c++) err_count_o[c*ERR_BITS +: ERR_BITS] = errcnt_q[c];
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_count_o    = '0;
`endif

endmodule

// File: tb/tb_cin_multi_parallel_sync.sv
// tb/tb_cin_multi_parallel_sync.sv - directed self-checking bench for cin_multi_parallel_sync
module tb_cin_multi_parallel_sync;

`ifdef CIN_SYNC_ERRCNT_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif

  logic        sysclk = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  lane0 = '0;
  logic [3:0]  lane1 = '0;
  logic [7:0]  cin_i;
  logic        lock_i = 1'b0;
  logic        capture_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [1:0]  locked, valid, biterr;
  logic [63:0] par, capd;
  logic [31:0] errc;
  logic [1:0]  locked2, valid2, biterr2;
  logic [63:0] par2, capd2;
  logic [3:0]  errc2;

  logic [31:0] tr_w = 32'hA55A6996;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, lock_cyc = 0, lk0_rise = 0, prev_v = 0;
  int v0_cnt = 0, be0_cnt = 0, cmd_cnt = 0, gap_err = 0;
  bit lk0_prev = 0, have_prev = 0;
  logic [31:0] last_w0 = '0;
  int be_loc, v_snap, be_snap, bound;

  assign cin_i = {lane1, lane0};

  cin_multi_parallel_sync #(.NCH(2), .NBITS(4), .WORD_BITS(32), .LOCK_COUNT(4), .ERR_BITS(16)) dut (
    .sysclk_i(sysclk), .rst_i(rst_i), .cin_i(cin_i), .lock_i(lock_i), .capture_i(capture_i),
    .err_clr_i(err_clr_i), .locked_o(locked), .cin_parallel_o(par), .cin_parallel_valid_o(valid),
    .cin_biterr_o(biterr), .capture_data_o(capd), .err_count_o(errc));

  cin_multi_parallel_sync #(.NCH(2), .NBITS(4), .WORD_BITS(32), .LOCK_COUNT(4), .ERR_BITS(2)) dut2 (
    .sysclk_i(sysclk), .rst_i(rst_i), .cin_i(cin_i), .lock_i(lock_i), .capture_i(capture_i),
    .err_clr_i(err_clr_i), .locked_o(locked2), .cin_parallel_o(par2), .cin_parallel_valid_o(valid2),
    .cin_biterr_o(biterr2), .capture_data_o(capd2), .err_count_o(errc2));

  always #5 sysclk = ~sysclk;

  initial begin
    forever begin
      for (int i = 0; i < 8; i++) begin
        lane1 = tr_w[31-4*i -: 4];
        @(posedge sysclk);
        #1;
      end
    end
  end

  always @(negedge sysclk) begin
    cyc++;
    if (locked[0] && !lk0_prev) lk0_rise = cyc;
    lk0_prev = locked[0];
    if (!locked[0]) have_prev = 0;
    if (valid[0]) begin
      v0_cnt++;
      last_w0 = par[31:0];
      if (par[31:0] == 32'h12345678) cmd_cnt++;
      if (have_prev && (cyc - prev_v) != 8) gap_err++;
      prev_v = cyc;
      have_prev = 1;
    end
    if (biterr[0]) be0_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_nyb(input logic [3:0] n);
    lane0 = n;
    @(posedge sysclk);
    #1;
    lock_i = 1'b0;
    capture_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit lock_last);
    for (int i = 0; i < 8; i++) begin
      if (lock_last && i == 7) lock_i = 1'b1;
      send_nyb(w[31-4*i -: 4]);
    end
    if (lock_last) lock_cyc = cyc;
  endtask

  initial begin
    repeat (3) send_nyb(4'h0);
    check("reset_locked", 64'(locked), 64'h0);
    check("reset_par", par, 64'h0);
    check("reset_valid_biterr", 64'({valid, biterr}), 64'h0);
    check("reset_capture", capd, 64'h0);
    check("reset_errcnt", 64'(errc), 64'h0);
    rst_i = 1'b0;
    repeat (4) send_nyb(4'h0);
    check("idle_no_valid", 64'(v0_cnt), 64'd0);
    check("idle_not_locked", 64'(locked), 64'h0);

    // IDLE error counting: all-zero lane0 mismatches at every boundary
    err_clr_i = 1'b1;
    send_nyb(4'h0);
    be_loc = 0;
    for (int i = 0; i < 40; i++) begin
      send_nyb(4'h0);
      if (biterr[0]) be_loc++;
    end
    check("idle_biterr_pulses", 64'(be_loc), 64'd5);
    check("errcnt_5", 64'(errc[15:0]), 64'(EN ? 5 : 0));
    check("errcnt_sat_2bit", 64'(errc2[1:0]), 64'(EN ? 3 : 0));
    bound = 0;
    for (int i = 0; i < 16 && !bound; i++) begin
      send_nyb(4'h0);
      if (biterr[0]) bound = 1;
    end
    check("idle_boundary_found", 64'(bound), 64'd1);
    repeat (7) send_nyb(4'h0);
    err_clr_i = 1'b1;
    send_nyb(4'h0);
    check("clr_coincident_biterr", 64'(biterr[0]), 64'd1);
    check("clr_wins", 64'(errc[15:0]), 64'h0);
    check("clr_wins_2bit", 64'(errc2[1:0]), 64'h0);

    // failed qualification: third word corrupted during CHECK
    send_word(tr_w, 0);
    send_word(tr_w, 0);
    send_word(tr_w, 1);
    send_word(tr_w, 0);
    send_word(32'h055A6996, 0);
    repeat (4) send_word(tr_w, 0);
    check("fail_qual_not_locked", 64'(locked[0]), 64'd0);
    send_word(tr_w, 0);
    check("fail_qual_relock_time", 64'(lk0_rise - lock_cyc), 64'd50);
    check("fail_qual_locked", 64'(locked[0]), 64'd1);
    check("lane1_unaffected", 64'(locked[1]), 64'd1);

    // relock while LOCKED with a 3-nybble skew
    repeat (3) send_nyb(4'h0);
    send_word(tr_w, 0);
    send_word(tr_w, 1);
    check("relock_drop", 64'(locked[0]), 64'd0);
    repeat (3) send_word(tr_w, 0);
    v_snap = v0_cnt;
    be_snap = be0_cnt;
    repeat (3) send_word(tr_w, 0);
    err_clr_i = 1'b1;
    send_word(tr_w, 0);
    check("lock_time_min", 64'(lk0_rise - lock_cyc), 64'd26);
    check("locked_valid_count", 64'(v0_cnt - v_snap), 64'd3);
    check("locked_no_biterr", 64'(be0_cnt - be_snap), 64'd0);
    check("locked_word", 64'(last_w0), 64'hA55A6996);
    check("valid_spacing", 64'(gap_err), 64'd0);

    // command word and capture
    send_word(32'h12345678, 0);
    capture_i = 1'b1;
    send_word(tr_w, 0);
    check("cmd_word", 64'(last_w0), 64'h12345678);
    check("cmd_biterr_once", 64'(be0_cnt - be_snap), 64'd1);
    check("capture_lane0", 64'(capd[31:0]), 64'h12345678);
    check("cmd_errcnt", 64'(errc[15:0]), 64'(EN ? 1 : 0));
    check("cmd_errcnt_2bit", 64'(errc2[1:0]), 64'(EN ? 1 : 0));
    send_word(tr_w, 0);
    check("cmd_single_strobe", 64'(cmd_cnt), 64'd1);
    check("post_cmd_word", 64'(last_w0), 64'hA55A6996);
    check("post_cmd_biterr", 64'(be0_cnt - be_snap), 64'd1);
    check("valid_spacing_end", 64'(gap_err), 64'd0);

    // asynchronous reset mid-stream
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_locked", 64'(locked), 64'h0);
    check("async_rst_par", par, 64'h0);
    check("async_rst_capture", capd, 64'h0);
    check("async_rst_flags", 64'({valid, biterr}), 64'h0);
    check("async_rst_errcnt", 64'(errc), 64'h0);
    send_nyb(4'h0);
    rst_i = 1'b0;
    v_snap = v0_cnt;
    repeat (3) send_word(tr_w, 0);
    check("post_rst_no_valid", 64'(v0_cnt - v_snap), 64'd0);
    check("post_rst_unlocked", 64'(locked), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
